// File: rtl/trig_window_pkg.sv
// Shared types and encodings for the trig_window capture block.
package trig_window_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    CAPTURE = ST_CAPTURE,
    DRAIN   = ST_DRAIN
  } state_e;

endpackage

// File: rtl/trig_window_if.sv
// AXI4-Stream style bundle carrying captured samples towards the DMA/BRAM writer.
interface trig_window_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/trig_window_axis_out_reg.sv
// One-entry AXI4-Stream output register. Accepts a sample when empty or when the
// current entry is leaving this cycle; otherwise flags the sample as dropped.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  load_req,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ok,
  output logic                  drop,
  output logic                  last_fire,
  trig_window_if.master         m_axis
);

  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  fire;

  // Entry bookkeeping: free on handshake, reload in the same cycle for full throughput.
  always_comb begin
    fire      = valid_q & m_axis.tready;
    load_ok   = load_req & (~valid_q | fire);
    drop      = load_req & valid_q & ~fire;
    last_fire = fire & last_q;
    valid_d   = valid_q & ~fire;
    last_d    = last_q & ~fire;
    data_d    = data_q;
    if (load_ok) begin
      valid_d = 1'b1;
      last_d  = load_last;
      data_d  = load_data;
    end
  end

  // Entry storage; data/last only change on load so they stay stable under backpressure.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tdata  = data_q;

endmodule

// File: rtl/trig_window.sv
// Triggered capture window: arm, wait for trigger, forward `length` samples with
// tlast on the final one, then pulse done once that beat is taken downstream.
module trig_window #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   arm,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic                   trig_in,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  trig_window_if.master          m_axis,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);
  import trig_window_pkg::*;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  logic                   load_req;
  logic                   load_ok;
  logic                   load_last;
  logic                   drop;
  logic                   last_fire;
  logic [COUNT_WIDTH-1:0] count_inc;

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk       (clk),
    .aresetn   (aresetn),
    .load_req  (load_req),
    .load_data (s_data),
    .load_last (load_last),
    .load_ok   (load_ok),
    .drop      (drop),
    .last_fire (last_fire),
    .m_axis    (m_axis)
  );

  // Window FSM, sample counter and sticky overflow; the trigger cycle already opens the window.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    load_req  = s_valid & (((state_q == ARMED) & trig_in) | (state_q == CAPTURE));
    count_inc = count_q + COUNT_WIDTH'(1);
    load_last = (count_inc == len_q);
    case (state_q)
      IDLE: begin
        if (arm && (length != '0)) begin
          state_d = ARMED;
          len_d   = length;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (trig_in) begin
          state_d = CAPTURE;
          if (load_ok) begin
            count_d = count_inc;
            if (load_last) state_d = DRAIN;
          end
        end
      end
      CAPTURE: begin
        if (load_ok) begin
          count_d = count_inc;
          if (load_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_fire) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (drop) ovf_d = 1'b1;
  end

  // Control state registers; reset abandons any window in flight.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
